// File: rtl/sipo_frame_controller.sv
// Serial-in/parallel-out frame controller: MSB-first word assembly, double-buffered valid/ready output, sticky overrun.
// Optional even-parity frame bit enabled by defining SIPO_FRAME_PARITY_EN.
module sipo_frame_controller #(
  parameter int unsigned WIDTH = 4,
`ifdef SIPO_FRAME_PARITY_EN
  localparam int unsigned FRAME_BITS = WIDTH + 1,
`else
  localparam int unsigned FRAME_BITS = WIDTH,
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_serial_in,
  input  logic             i_bit_valid,
  input  logic             i_out_ready,
  input  logic             i_overrun_clr,
  output logic [WIDTH-1:0] o_parallel_out,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_count,
  output logic             o_overrun,
  output logic             o_parity_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FULL} state_t;

  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_shift,     w_shift_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [WIDTH-1:0] r_hold,      w_hold_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_overrun,   w_overrun_nxt;
  logic             r_perr,      w_perr_nxt;
  logic             r_par,       w_par_nxt;

  logic             w_hold_free;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_frame_perr;
  logic             w_par_upd;

  assign w_hold_free = ~r_out_valid | i_out_ready;
  assign w_last_bit  = (r_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_shifted   = {r_shift[WIDTH-2:0], i_serial_in};

  // With parity the final bit is the parity bit, so the word is already complete in r_shift.
`ifdef SIPO_FRAME_PARITY_EN
  assign w_word       = r_shift;
  assign w_frame_perr = r_par ^ i_serial_in;
  assign w_par_upd    = r_par ^ i_serial_in;
`else
  assign w_word       = w_shifted;
  assign w_frame_perr = 1'b0;
  assign w_par_upd    = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_out_valid_nxt = r_out_valid & ~i_out_ready;
    w_overrun_nxt   = r_overrun & ~i_overrun_clr;
    w_perr_nxt      = r_perr;
    w_par_nxt       = r_par;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_par_nxt   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (i_start) begin
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_par_nxt   = 1'b0;
        end else if (i_bit_valid) begin
          if (w_last_bit) begin
            if (w_hold_free) begin
              w_hold_nxt      = w_word;
              w_perr_nxt      = w_frame_perr;
              w_out_valid_nxt = 1'b1;
              w_shift_nxt     = w_word;
              w_cnt_nxt       = '0;
              w_state_nxt     = ST_IDLE;
            end else begin
              // Holding register busy: park the word (and its parity result) until accepted.
              w_shift_nxt = w_word;
              w_par_nxt   = w_frame_perr;
              w_cnt_nxt   = CNT_W'(FRAME_BITS);
              w_state_nxt = ST_FULL;
            end
          end else begin
            w_shift_nxt = w_shifted;
            w_par_nxt   = w_par_upd;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (i_bit_valid) begin
          w_overrun_nxt = 1'b1;
        end
        if (r_out_valid && i_out_ready) begin
          w_hold_nxt      = r_shift;
          w_perr_nxt      = r_par;
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_perr      <= 1'b0;
      r_par       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
      r_perr      <= w_perr_nxt;
      r_par       <= w_par_nxt;
    end
  end

  assign o_parallel_out = r_hold;
  assign o_out_valid    = r_out_valid;
  assign o_busy         = r_busy;
  assign o_bit_count    = r_cnt;
  assign o_overrun      = r_overrun;
  assign o_parity_err   = r_perr;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Self-checking bench for sipo_frame_controller: directed scenarios plus random traffic against a queue-based reference model.
module tb_sipo_frame_controller;

  localparam int unsigned WIDTH = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FRAME + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, serial_in, bit_valid, out_ready, overrun_clr;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid, busy, overrun, parity_err;
  logic [CW-1:0]    bit_count;

  int n_cmp = 0;
  int n_bad = 0;

  sipo_frame_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_serial_in(serial_in),
    .i_bit_valid(bit_valid), .i_out_ready(out_ready), .i_overrun_clr(overrun_clr),
    .o_parallel_out(parallel_out), .o_out_valid(out_valid), .o_busy(busy),
    .o_bit_count(bit_count), .o_overrun(overrun), .o_parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Reference model: frame bits collected in a queue; q_word[0] is the visible word, q_word[1] a parked one.
  bit               m_active;
  bit               m_bits[$];
  logic [WIDTH-1:0] q_word[$];
  bit               q_perr[$];
  logic [WIDTH-1:0] m_last_word;
  bit               m_last_perr;
  bit               m_ovr;

  function automatic void model_reset();
    m_active = 1'b0;
    m_bits.delete();
    q_word.delete();
    q_perr.delete();
    m_last_word = '0;
    m_last_perr = 1'b0;
    m_ovr = 1'b0;
  endfunction

  function automatic void model_step();
    bit               was_full;
    bit               acc;
    logic [WIDTH-1:0] w;
    bit               p;
    was_full = (q_word.size() == 2);
    acc = (q_word.size() > 0) && out_ready;
    if (overrun_clr) m_ovr = 1'b0;
    if (acc) begin
      void'(q_word.pop_front());
      void'(q_perr.pop_front());
    end
    if (was_full) begin
      if (bit_valid) m_ovr = 1'b1;
    end else if (m_active) begin
      if (start) begin
        m_bits.delete();
      end else if (bit_valid) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() == FRAME) begin
          w = '0;
          p = 1'b0;
          for (int i = 0; i < int'(WIDTH); i++) w = (w << 1) | WIDTH'(m_bits[i]);
          for (int i = 0; i < int'(FRAME); i++) p = p ^ m_bits[i];
`ifndef SIPO_FRAME_PARITY_EN
          p = 1'b0;
`endif
          q_word.push_back(w);
          q_perr.push_back(p);
          m_bits.delete();
          m_active = 1'b0;
        end
      end
    end else if (start) begin
      m_active = 1'b1;
      m_bits.delete();
    end
    if (q_word.size() > 0) begin
      m_last_word = q_word[0];
      m_last_perr = q_perr[0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic st, input logic bv, input logic sin, input logic clr);
    start = st; bit_valid = bv; serial_in = sin; overrun_clr = clr;
    tick();
    start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic pbit);
    logic [WIDTH-1:0] wv;
    wv = w;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) drive(1'b0, 1'b1, wv[i], 1'b0);
`ifdef SIPO_FRAME_PARITY_EN
    drive(1'b0, 1'b1, pbit, 1'b0);
`else
    if (pbit) begin end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; serial_in = 0; bit_valid = 0; out_ready = 1; overrun_clr = 0;
    model_reset();
    #2;
    n_cmp++; if ({out_valid, busy, overrun, parity_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, overrun, parity_err}); end
    n_cmp++; if (parallel_out !== '0) begin n_bad++; $display("FAIL reset_word: got %b want 0", parallel_out); end
    n_cmp++; if (bit_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bit_count); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start: got %b want 1", busy); end
    send_word(4'b1011, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (parallel_out !== 4'b1011) begin n_bad++; $display("FAIL basic_word: got %b want 1011", parallel_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); rst_n = 1'b0; model_reset();
    #1;
    n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rstmid_flags: got %b want 00", {out_valid, busy}); end
    n_cmp++; if (bit_count !== '0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", bit_count); end
    n_cmp++; if (parallel_out !== 4'b0000) begin n_bad++; $display("FAIL rstmid_word: got %b want 0000", parallel_out); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++; if ({busy, out_valid, bit_count} !== {2'b00, CW'(0)}) begin n_bad++; $display("FAIL rstmid_ignore: got busy=%b valid=%b cnt=%0d want idle", busy, out_valid, bit_count); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b1011, 1'b1);
    n_cmp++; if ({out_valid, parallel_out} !== {1'b1, 4'b1011}) begin n_bad++; $display("FAIL bp_first: got v=%b %b want v=1 1011", out_valid, parallel_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({out_valid, parallel_out} !== {1'b1, 4'b1011}) begin n_bad++; $display("FAIL bp_hold: got v=%b %b want v=1 1011", out_valid, parallel_out); end
    send_word(4'b0110, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_full_busy: got %b want 1", busy); end
    n_cmp++; if (bit_count !== CW'(FRAME)) begin n_bad++; $display("FAIL bp_full_count: got %0d want %0d", bit_count, FRAME); end
    n_cmp++; if (parallel_out !== 4'b1011) begin n_bad++; $display("FAIL bp_full_word: got %b want 1011", parallel_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL bp_no_overrun: got %b want 0", overrun); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({overrun, busy, parallel_out} !== {2'b11, 4'b1011}) begin n_bad++; $display("FAIL bp_overrun: got ovr=%b busy=%b %b want 1 1 1011", overrun, busy, parallel_out); end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({out_valid, parallel_out} !== {1'b1, 4'b0110}) begin n_bad++; $display("FAIL bp_second: got v=%b %b want v=1 0110", out_valid, parallel_out); end
    n_cmp++; if ({overrun, busy, bit_count} !== {2'b10, CW'(0)}) begin n_bad++; $display("FAIL bp_after_accept: got ovr=%b busy=%b cnt=%0d want 1 0 0", overrun, busy, bit_count); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({out_valid, overrun} !== 2'b01) begin n_bad++; $display("FAIL bp_drain: got v=%b ovr=%b want 0 1", out_valid, overrun); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL bp_ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_abort_gaps();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({busy, bit_count} !== {1'b1, CW'(0)}) begin n_bad++; $display("FAIL abort_clear: got busy=%b cnt=%0d want 1 0", busy, bit_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, (i == 3) ? 1'b1 : 1'b0, 1'b0);
      if (i < 3 || FRAME > WIDTH) begin
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bit_count !== CW'(i + 1)) begin n_bad++; $display("FAIL gap_hold_%0d: got %0d want %0d", i, bit_count, i + 1); end
      end
    end
`ifdef SIPO_FRAME_PARITY_EN
    drive(1'b0, 1'b1, 1'b1, 1'b0);
`endif
    n_cmp++; if ({out_valid, parallel_out} !== {1'b1, 4'b0001}) begin n_bad++; $display("FAIL gap_word: got v=%b %b want v=1 0001", out_valid, parallel_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b1011, 1'b1);
    n_cmp++; if ({parallel_out, parity_err} !== {4'b1011, 1'b0}) begin n_bad++; $display("FAIL parity_good: got %b perr=%b want 1011 perr=0", parallel_out, parity_err); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b1011, 1'b0);
`ifdef SIPO_FRAME_PARITY_EN
    n_cmp++; if ({parallel_out, parity_err} !== {4'b1011, 1'b1}) begin n_bad++; $display("FAIL parity_bad: got %b perr=%b want 1011 perr=1", parallel_out, parity_err); end
`else
    n_cmp++; if ({parallel_out, parity_err} !== {4'b1011, 1'b0}) begin n_bad++; $display("FAIL parity_off: got %b perr=%b want 1011 perr=0", parallel_out, parity_err); end
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      out_ready = (c % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 30) == 0));
      n_cmp++; if (out_valid !== (q_word.size() > 0)) begin n_bad++; $display("FAIL rnd_valid @%0d: got %b want %b", c, out_valid, q_word.size() > 0); end
      n_cmp++; if (parallel_out !== m_last_word) begin n_bad++; $display("FAIL rnd_word @%0d: got %b want %b", c, parallel_out, m_last_word); end
      n_cmp++; if (busy !== (m_active || q_word.size() == 2)) begin n_bad++; $display("FAIL rnd_busy @%0d: got %b want %b", c, busy, m_active || q_word.size() == 2); end
      n_cmp++; if (bit_count !== ((q_word.size() == 2) ? CW'(FRAME) : CW'(m_bits.size()))) begin n_bad++; $display("FAIL rnd_count @%0d: got %0d", c, bit_count); end
      n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rnd_overrun @%0d: got %b want %b", c, overrun, m_ovr); end
      n_cmp++; if (parity_err !== m_last_perr) begin n_bad++; $display("FAIL rnd_perr @%0d: got %b want %b", c, parity_err, m_last_perr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_backpressure();
    test_abort_gaps();
    test_parity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_controller.md
Name: sipo_frame_controller

Overview:
- Sequences a serial-in/parallel-out shift datapath: frames a word on a start pulse, counts qualified serial bits MSB-first, and hands the assembled word downstream on a valid/ready handshake.
- Double-buffered: internal shift register plus output holding register, so one word can assemble while the previous word waits.
- Back-pressure stalls the frame, and bits lost during a stall are flagged.
- Sits between a bit-level serial receiver and a word-level consumer.

Parameters:
- WIDTH, 4, word width in bits (>=2); bit counter width is derived internally as $clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle pulse; begins a new frame.
- serial_in  input  1  serial data bit, sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in for this cycle.
- parallel_out  output  WIDTH  holding-register word; first received bit lands in the MSB.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid&&out_ready.
- busy  output  1  1 in SHIFT or FULL.
- bit_count  output  $clog2(WIDTH+1)  bits captured in the current frame.
- overrun  output  1  sticky; a bit_valid arrived in FULL.
- overrun_clr  input  1  synchronous clear of overrun.
- parity_err  output  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset=0, async): state=IDLE; shift register, parallel_out, bit_count = 0; out_valid, overrun, parity_err = 0.
- States: IDLE, SHIFT, FULL.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> SHIFT, bit_count=0, shift register cleared.
- SHIFT:
  - bit_valid=1: shift <= {shift[WIDTH-2:0], serial_in}; bit_count+1.
  - bit_valid=0: shift register and bit_count hold, so gaps between bits are allowed.
- Word completion: on the bit_valid that makes bit_count reach WIDTH.
  - If the holding register is free (out_valid=0, or out_valid&&out_ready this cycle): load the holding register with the final word (including the current bit). out_valid=1 on the next cycle (latency 1 clock after the last bit edge). bit_count=0; -> IDLE.
  - Else -> FULL; the completed word stays in the shift register.
- FULL:
  - busy=1; bit_count holds at WIDTH.
  - Any bit_valid sets overrun; the bit is dropped.
  - When out_valid&&out_ready: the shift-register word moves to the holding register, out_valid stays 1 (new word next cycle), bit_count=0, -> IDLE.
- start in SHIFT: aborts the partial word; shift register and bit_count cleared, stay in SHIFT. The start pulse has priority over a simultaneous bit_valid, which is dropped.
- start in FULL: ignored.
- Output handshake:
  - parallel_out and out_valid stay stable while out_valid=1 && out_ready=0.
  - out_valid clears the cycle after acceptance unless a new word loads in that same cycle.
- overrun: cleared only by overrun_clr or reset. If overrun_clr and a set event occur in the same cycle, the set wins.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_EN.
- Defined:
  - A frame is WIDTH data bits followed by one even-parity bit; completion happens on bit WIDTH+1, and bit_count counts to WIDTH+1.
  - The parity bit is not shifted into the word.
  - parity_err is registered alongside the word load: 1 if XOR of the data bits and the parity bit is 1.
  - parity_err is valid while out_valid=1 and holds with its word.
- Undefined: WIDTH-bit frames; parity_err is constant 0.

Test Plan:
- Reset mid-frame: start, bits 1,1, then reset=0 for 1 cycle -> immediately out_valid=0, busy=0, bit_count=0, parallel_out=0000; subsequent bit_valid ignored until start.
- Basic word (out_ready=1): start, bits 1,0,1,1 on consecutive cycles -> one cycle after the 4th bit, out_valid=1 and parallel_out=4'b1011 for 1 cycle; busy=0.
- Back-pressure (out_ready=0): words 1011 then 0110 -> 1011 held with out_valid=1; after the 2nd word, busy=1 (FULL); an extra bit_valid -> overrun=1. Raise out_ready -> 1011 accepted, next cycle parallel_out=0110, out_valid=1; overrun stays 1 until overrun_clr.
- Abort and gaps: start, bits 1,1, start, then bits 0,0,0,1 separated by 2 idle cycles each -> bit_count holds across gaps; parallel_out=4'b0001.
- Parity (SIPO_FRAME_PARITY_EN): 1011 + parity bit 1 -> parallel_out=1011, parity_err=0. 1011 + parity bit 0 -> parity_err=1.
